pipe_scroller: RTL

PIPE_SCROLLER -- requirements
Module: pipe_scroller

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_column.sv | 39 +++
 rtl/pipe_scroller.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipe scroller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam int DEF_ROWS = 16;
  localparam int DEF_COLS = 16;

  // One column of LEDs, one bit per row.
  typedef logic [DEF_ROWS-1:0] col_t;

endpackage

// File: rtl/pipe_column.sv
// One ROWS-bit column register with clear (priority), load and hold.
// Latency: q follows d one clock after load.
// Backpressure: none; load is a qualified enable from the scroller.
// Ports: clk, reset (async, active-high), load, clear, d in, q out.
module pipe_column
  import pipe_pkg::*;
#(
  parameter int ROWS = DEF_ROWS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            clear,
  input  logic [ROWS-1:0] d,
  output logic [ROWS-1:0] q
);

  logic [ROWS-1:0] col_q, col_d;

  always_comb begin
    col_d = col_q;
    if (clear) begin
      col_d = '0;
    end else if (load) begin
      col_d = d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= '0;
    end else begin
      col_q <= col_d;
    end
  end

  assign q = col_q;

endmodule

// File: rtl/pipe_scroller.sv
// Scrolling pipe field with gap injection, bird collision and score.
// Latency: field/hit/score/state update one clock after the sampling edge.
// Backpressure: none; a step that cannot be taken (freeze/collision) is dropped.
// Ports: clk, reset (async, active-high), start, step, gameover, new_pipe,
//        bird_mask in; pipe_req, field, hit, score, state out.
// Config: define PIPE_SCROLLER_SCORE_EN to build the score counter,
//         otherwise score is tied to zero.
module pipe_scroller
  import pipe_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int GAP_COLS = 4,
  parameter int BIRD_COL = 3,
  parameter int SCORE_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 step,
  input  logic                 gameover,
  input  logic [ROWS-1:0]      new_pipe,
  input  logic [ROWS-1:0]      bird_mask,
  output logic                 pipe_req,
  output logic [ROWS*COLS-1:0] field,
  output logic                 hit,
  output logic [SCORE_W-1:0]   score,
  output logic [1:0]           state
);

  localparam int GAP_W = (GAP_COLS < 1) ? 1 : $clog2(GAP_COLS + 1);

  state_e           state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             hit_q, hit_d;
  logic             pipe_req_q, pipe_req_d;

  logic [ROWS-1:0]  col_q [COLS];

  logic             coll;    // bird overlaps the pipe column this cycle
  logic             adv;     // a step that actually shifts the field
  logic             inject;  // this shift loads new_pipe into column 0
  logic             clr;     // HALT -> IDLE wipe

  always_comb begin
    coll   = (state_q == RUN) && (|(col_q[BIRD_COL] & bird_mask));
    // A freeze or a collision being latched this edge swallows the step.
    adv    = (state_q == RUN) && step && !gameover && !coll;
    inject = adv && (gap_cnt_q == GAP_W'(GAP_COLS));
    clr    = (state_q == HALT) && start;
  end

  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    hit_d      = hit_q;
    pipe_req_d = inject;

    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (gameover || coll || hit_q) state_d = HALT;
      HALT:    if (start) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (clr) begin
      gap_cnt_d = '0;
      hit_d     = 1'b0;
    end else begin
      if (adv) begin
        gap_cnt_d = inject ? '0 : gap_cnt_q + 1'b1;
      end
      if (coll) begin
        hit_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      gap_cnt_q  <= '0;
      hit_q      <= 1'b0;
      pipe_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      hit_q      <= hit_d;
      pipe_req_q <= pipe_req_d;
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [ROWS-1:0] col_in;
    if (c == 0) begin : g_entry
      assign col_in = inject ? new_pipe : '0;
    end else begin : g_body
      assign col_in = col_q[c-1];
    end

    pipe_column #(.ROWS(ROWS)) u_col (
      .clk   (clk),
      .reset (reset),
      .load  (adv),
      .clear (clr),
      .d     (col_in),
      .q     (col_q[c])
    );

    assign field[c*ROWS +: ROWS] = col_q[c];
  end

`ifdef PIPE_SCROLLER_SCORE_EN
  logic [SCORE_W-1:0] score_q, score_d;

  // A pipe leaving the bird column: occupied now, next column still empty.
  always_comb begin
    score_d = score_q;
    if (clr) begin
      score_d = '0;
    end else if (adv && (|col_q[BIRD_COL]) && !(|col_q[BIRD_COL+1]) && !(&score_q)) begin
      score_d = score_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

  assign state    = state_q;
  assign hit      = hit_q;
  assign pipe_req = pipe_req_q;

endmodule
